// File: rtl/mem_arb_pkg.sv
// Shared types and limits for the fetch/LSU memory port arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    BUSY_I,
    BUSY_D
  } arb_state_e;

  localparam int unsigned MAX_LATENCY = 8;
  localparam int unsigned LAT_W       = $clog2(MAX_LATENCY);

endpackage

// File: rtl/mem_lat_timer.sv
// Loadable down-counter that tracks one outstanding memory access.
// done marks the final cycle of the access; busy covers the whole access.
module mem_lat_timer
  import mem_arb_pkg::*;
#(
  parameter int unsigned WIDTH = LAT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic             done,
  output logic             busy
);

  logic [WIDTH-1:0] count_q, count_d;
  logic             busy_q, busy_d;

  always_comb begin
    count_d = count_q;
    busy_d  = busy_q;
    if (load) begin
      count_d = load_value;
      busy_d  = 1'b1;
    end else if (busy_q) begin
      if (count_q == '0) begin
        busy_d = 1'b0;
      end else begin
        count_d = count_q - WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
      busy_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      busy_q  <= busy_d;
    end
  end

  assign done = busy_q && (count_q == '0);
  assign busy = busy_q;

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between instruction fetch and the LSU.
// Optional fetch anti-starvation guard: define ARB_STARVE_GUARD_EN.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned MEM_LATENCY  = 1,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_req,
  input  logic [31:0] i_address,
  output logic        i_grant,
  output logic        i_rvalid,
  output logic [31:0] i_rdata,
  input  logic        redirect,
  input  logic        d_req,
  input  logic [3:0]  d_we,
  input  logic [31:0] d_address,
  input  logic [31:0] d_wdata,
  output logic        d_grant,
  output logic        d_rvalid,
  output logic [31:0] d_rdata,
  output logic        mem_en,
  output logic [3:0]  mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  arb_state_e state_q, state_d;
  logic       kill_q, kill_d;
  logic       tmr_done, tmr_busy;
  logic       can_grant, force_i;

  mem_lat_timer #(.WIDTH(LAT_W)) u_timer (
    .clk        (clk),
    .rst_n      (reset),
    .load       (mem_en),
    .load_value (LAT_W'(MEM_LATENCY - 1)),
    .done       (tmr_done),
    .busy       (tmr_busy)
  );

  // Reset gates the grant path so every output is 0 while reset is held.
  assign can_grant = reset && (!tmr_busy || tmr_done);
  assign d_grant   = can_grant && d_req && !force_i;
  assign i_grant   = can_grant && i_req && (!d_req || force_i);

`ifdef ARB_STARVE_GUARD_EN
  localparam int unsigned STARVE_W = $clog2(STARVE_LIMIT + 1);

  logic [STARVE_W-1:0] starve_q, starve_d;

  assign force_i = (starve_q == STARVE_W'(STARVE_LIMIT)) && i_req && d_req;

  always_comb begin
    starve_d = starve_q;
    if (!i_req || i_grant) begin
      starve_d = '0;
    end else if (d_grant) begin
      starve_d = starve_q + STARVE_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      starve_q <= '0;
    end else begin
      starve_q <= starve_d;
    end
  end
`else
  logic unused_starve_limit;

  assign force_i             = 1'b0;
  assign unused_starve_limit = (STARVE_LIMIT == 0);
`endif

  always_comb begin
    state_d = state_q;
    kill_d  = kill_q;
    if (tmr_done) begin
      state_d = IDLE;
      kill_d  = 1'b0;
    end else if ((state_q == BUSY_I) && redirect) begin
      kill_d = 1'b1;
    end
    if (d_grant) begin
      state_d = BUSY_D;
    end else if (i_grant) begin
      state_d = BUSY_I;
      kill_d  = redirect;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      kill_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      kill_q  <= kill_d;
    end
  end

  // A redirect landing on the completion cycle itself also drops the stale word.
  assign i_rvalid = tmr_done && (state_q == BUSY_I) && !kill_q && !redirect;
  assign d_rvalid = tmr_done && (state_q == BUSY_D);
  assign i_rdata  = i_rvalid ? mem_rdata : '0;
  assign d_rdata  = d_rvalid ? mem_rdata : '0;

  assign mem_en    = i_grant || d_grant;
  assign mem_we    = d_grant ? d_we : '0;
  assign mem_addr  = d_grant ? d_address : (i_grant ? i_address : '0);
  assign mem_wdata = d_grant ? d_wdata : '0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: three instances (latency 1, 3, 4), a transaction-level
// reference model checked every cycle, plus directed literal expectations.
`timescale 1ns/1ps
module tb_mem_port_arbiter;

  localparam int unsigned NI     = 3;
  localparam int unsigned STARVE = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic        i_req_s    [NI];
  logic [31:0] i_addr_s   [NI];
  logic        redirect_s [NI];
  logic        d_req_s    [NI];
  logic [3:0]  d_we_s     [NI];
  logic [31:0] d_addr_s   [NI];
  logic [31:0] d_wdata_s  [NI];
  logic        i_grant_s  [NI];
  logic        i_rvalid_s [NI];
  logic [31:0] i_rdata_s  [NI];
  logic        d_grant_s  [NI];
  logic        d_rvalid_s [NI];
  logic [31:0] d_rdata_s  [NI];
  logic        mem_en_s   [NI];
  logic [3:0]  mem_we_s   [NI];
  logic [31:0] mem_addr_s [NI];
  logic [31:0] mem_wdata_s[NI];
  logic [31:0] mem_rdata_s[NI];

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;
  int unsigned cyc   = 0;

  function automatic logic [31:0] memword(input logic [31:0] a);
    if (a == 32'h0000_3000) return 32'h1234_5678;
    return a * 32'd3 + 32'h1000_0000;
  endfunction

  function automatic int unsigned lat_of(input int unsigned g);
    return (g == 0) ? 1 : (g == 1) ? 3 : 4;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      if (n_bad <= 40) $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam int unsigned L = (g == 0) ? 1 : (g == 1) ? 3 : 4;
    bit        pv [L];
    bit [31:0] pa [L];

    mem_port_arbiter #(.MEM_LATENCY(L), .STARVE_LIMIT(STARVE)) u_dut (
      .clk       (clk),
      .reset     (reset),
      .i_req     (i_req_s[g]),
      .i_address (i_addr_s[g]),
      .i_grant   (i_grant_s[g]),
      .i_rvalid  (i_rvalid_s[g]),
      .i_rdata   (i_rdata_s[g]),
      .redirect  (redirect_s[g]),
      .d_req     (d_req_s[g]),
      .d_we      (d_we_s[g]),
      .d_address (d_addr_s[g]),
      .d_wdata   (d_wdata_s[g]),
      .d_grant   (d_grant_s[g]),
      .d_rvalid  (d_rvalid_s[g]),
      .d_rdata   (d_rdata_s[g]),
      .mem_en    (mem_en_s[g]),
      .mem_we    (mem_we_s[g]),
      .mem_addr  (mem_addr_s[g]),
      .mem_wdata (mem_wdata_s[g]),
      .mem_rdata (mem_rdata_s[g])
    );

    // Memory stand-in: returns memword(addr) exactly L cycles after the strobe.
    always @(posedge clk) begin
      pv[0] <= mem_en_s[g];
      pa[0] <= mem_addr_s[g];
      for (int k = 1; k < L; k++) begin
        pv[k] <= pv[k-1];
        pa[k] <= pa[k-1];
      end
    end
    assign mem_rdata_s[g] = pv[L-1] ? memword(pa[L-1]) : 32'hCAFE_F00D;
  end

  typedef struct {
    bit          busy;
    bit          own_d;
    int unsigned due;
    bit          killed;
    logic [31:0] addr;
    int unsigned starve;
  } mdl_t;

  mdl_t mdl [NI];

  task automatic model_step(input int unsigned g);
    bit done, gi, gd, e_irv, e_drv;
    string p;
    p = $sformatf("u%0d.", g);
    done = 0; gi = 0; gd = 0;
    if (reset) begin
      done = mdl[g].busy && (mdl[g].due == cyc);
      if (!mdl[g].busy || done) begin
        if (i_req_s[g] && d_req_s[g]) begin
`ifdef ARB_STARVE_GUARD_EN
          if (mdl[g].starve == STARVE) gi = 1; else gd = 1;
`else
          gd = 1;
`endif
        end else begin
          gi = i_req_s[g];
          gd = d_req_s[g];
        end
      end
    end
    e_irv = done && !mdl[g].own_d && !mdl[g].killed && !redirect_s[g];
    e_drv = done && mdl[g].own_d;

    chk({p, "i_grant"},   i_grant_s[g],   gi);
    chk({p, "d_grant"},   d_grant_s[g],   gd);
    chk({p, "mem_en"},    mem_en_s[g],    gi | gd);
    chk({p, "mem_we"},    mem_we_s[g],    gd ? d_we_s[g] : 4'h0);
    chk({p, "mem_addr"},  mem_addr_s[g],  gd ? d_addr_s[g] : (gi ? i_addr_s[g] : 32'h0));
    chk({p, "mem_wdata"}, mem_wdata_s[g], gd ? d_wdata_s[g] : 32'h0);
    chk({p, "i_rvalid"},  i_rvalid_s[g],  e_irv);
    chk({p, "i_rdata"},   i_rdata_s[g],   e_irv ? memword(mdl[g].addr) : 32'h0);
    chk({p, "d_rvalid"},  d_rvalid_s[g],  e_drv);
    chk({p, "d_rdata"},   d_rdata_s[g],   e_drv ? memword(mdl[g].addr) : 32'h0);

    if (!reset) begin
      mdl[g].busy   = 0;
      mdl[g].starve = 0;
    end else begin
      if (mdl[g].busy && !mdl[g].own_d && redirect_s[g]) mdl[g].killed = 1;
      if (done) mdl[g].busy = 0;
      if (gi || gd) begin
        mdl[g].busy   = 1;
        mdl[g].own_d  = gd;
        mdl[g].due    = cyc + lat_of(g);
        mdl[g].killed = gi && redirect_s[g];
        mdl[g].addr   = gd ? d_addr_s[g] : i_addr_s[g];
      end
      if (!i_req_s[g] || gi) mdl[g].starve = 0;
      else if (gd) mdl[g].starve = mdl[g].starve + 1;
    end
  endtask

  initial begin
    for (int unsigned g = 0; g < NI; g++) begin
      mdl[g].busy   = 0;
      mdl[g].starve = 0;
    end
    forever begin
      @(negedge clk);
      for (int unsigned g = 0; g < NI; g++) model_step(g);
      cyc++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic clr_inputs();
    for (int unsigned g = 0; g < NI; g++) begin
      i_req_s[g]    = 1'b0;
      i_addr_s[g]   = '0;
      redirect_s[g] = 1'b0;
      d_req_s[g]    = 1'b0;
      d_we_s[g]     = '0;
      d_addr_s[g]   = '0;
      d_wdata_s[g]  = '0;
    end
  endtask

  logic [3:0] vec_tab [16];
  logic       exp_d;

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached before end of stimulus");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_tab = '{4'b1100, 4'b1101, 4'b1000, 4'b1010, 4'b0100, 4'b1110, 4'b1100, 4'b0010,
                4'b1000, 4'b1000, 4'b1011, 4'b0101, 4'b1100, 4'b0000, 4'b1010, 4'b1100};
    reset = 1'b0;
    clr_inputs();
    i_req_s[0] = 1'b1;
    d_req_s[1] = 1'b1;
    repeat (3) tick();
    sample();
    chk("rst.i_grant0", i_grant_s[0], 1'b0);
    chk("rst.mem_en0",  mem_en_s[0],  1'b0);
    chk("rst.d_grant1", d_grant_s[1], 1'b0);
    chk("rst.mem_en1",  mem_en_s[1],  1'b0);
    tick();
    clr_inputs();
    reset = 1'b1;

    // A: latency 1, back-to-back fetches
    tick();
    i_req_s[0] = 1'b1; i_addr_s[0] = 32'h100;
    sample();
    chk("A.grant0", i_grant_s[0], 1'b1);
    chk("A.addr0",  mem_addr_s[0], 32'h100);
    chk("A.we0",    mem_we_s[0], 4'h0);
    tick();
    i_addr_s[0] = 32'h104;
    sample();
    chk("A.rvalid0", i_rvalid_s[0], 1'b1);
    chk("A.rdata0",  i_rdata_s[0], 32'h1000_0300);
    chk("A.grant1",  i_grant_s[0], 1'b1);
    chk("A.addr1",   mem_addr_s[0], 32'h104);
    tick();
    i_req_s[0] = 1'b0;
    sample();
    chk("A.rvalid1", i_rvalid_s[0], 1'b1);
    chk("A.rdata1",  i_rdata_s[0], 32'h1000_030C);
    chk("A.idle_en", mem_en_s[0], 1'b0);
    tick();
    sample();
    chk("A.rvalid_off", i_rvalid_s[0], 1'b0);
    chk("A.rdata_off",  i_rdata_s[0], 32'h0);

    // B: data beats fetch, fetch follows in the completion cycle
    tick();
    i_req_s[0] = 1'b1; i_addr_s[0] = 32'h200;
    d_req_s[0] = 1'b1; d_we_s[0] = 4'hF; d_addr_s[0] = 32'h2000; d_wdata_s[0] = 32'hDEAD_BEEF;
    sample();
    chk("B.d_grant", d_grant_s[0], 1'b1);
    chk("B.i_grant", i_grant_s[0], 1'b0);
    chk("B.mem_we",  mem_we_s[0], 4'hF);
    chk("B.wdata",   mem_wdata_s[0], 32'hDEAD_BEEF);
    chk("B.addr",    mem_addr_s[0], 32'h2000);
    tick();
    d_req_s[0] = 1'b0; d_we_s[0] = 4'h0;
    sample();
    chk("B.d_rvalid", d_rvalid_s[0], 1'b1);
    chk("B.d_rdata",  d_rdata_s[0], 32'h1000_6000);
    chk("B.i_grant2", i_grant_s[0], 1'b1);
    chk("B.addr2",    mem_addr_s[0], 32'h200);
    chk("B.we2",      mem_we_s[0], 4'h0);
    tick();
    i_req_s[0] = 1'b0;
    sample();
    chk("B.i_rvalid", i_rvalid_s[0], 1'b1);
    chk("B.i_rdata",  i_rdata_s[0], 32'h1000_0600);
    chk("B.d_rv_off", d_rvalid_s[0], 1'b0);

    // C: latency 3, redirect kills in-flight fetch
    tick();
    i_req_s[1] = 1'b1; i_addr_s[1] = 32'h300;
    sample();
    chk("C.grant", i_grant_s[1], 1'b1);
    tick();
    i_req_s[1] = 1'b0; redirect_s[1] = 1'b1;
    sample();
    chk("C.en1", mem_en_s[1], 1'b0);
    tick();
    redirect_s[1] = 1'b0;
    sample();
    chk("C.en2", mem_en_s[1], 1'b0);
    tick();
    i_req_s[1] = 1'b1; i_addr_s[1] = 32'h304;
    sample();
    chk("C.killed_rv", i_rvalid_s[1], 1'b0);
    chk("C.killed_rd", i_rdata_s[1], 32'h0);
    chk("C.regrant",   i_grant_s[1], 1'b1);
    tick();
    i_req_s[1] = 1'b0;
    tick();
    tick();
    sample();
    chk("C.rvalid", i_rvalid_s[1], 1'b1);
    chk("C.rdata",  i_rdata_s[1], 32'h1000_090C);
    tick();
    redirect_s[1] = 1'b1;
    tick();
    redirect_s[1] = 1'b0; i_req_s[1] = 1'b1; i_addr_s[1] = 32'h400;
    sample();
    chk("C.idle_redir_grant", i_grant_s[1], 1'b1);
    tick();
    i_req_s[1] = 1'b0;
    tick();
    tick();
    sample();
    chk("C.idle_redir_rv", i_rvalid_s[1], 1'b1);
    chk("C.idle_redir_rd", i_rdata_s[1], 32'h1000_0C00);
    tick();
    d_req_s[1] = 1'b1; d_addr_s[1] = 32'h3000;
    sample();
    chk("F.d_grant", d_grant_s[1], 1'b1);
    tick();
    d_req_s[1] = 1'b0; redirect_s[1] = 1'b1;
    tick();
    redirect_s[1] = 1'b0;
    tick();
    sample();
    chk("F.d_rvalid", d_rvalid_s[1], 1'b1);
    chk("F.d_rdata",  d_rdata_s[1], 32'h1234_5678);
    chk("F.i_rvalid", i_rvalid_s[1], 1'b0);
    tick();
    sample();
    chk("F.d_rv_once", d_rvalid_s[1], 1'b0);
    chk("F.d_rd_zero", d_rdata_s[1], 32'h0);

    // D: both requests held continuously at latency 1
    tick();
    i_req_s[0] = 1'b1; i_addr_s[0] = 32'h500;
    d_req_s[0] = 1'b1; d_addr_s[0] = 32'h600; d_we_s[0] = 4'h0;
    for (int k = 0; k < 10; k++) begin
      sample();
`ifdef ARB_STARVE_GUARD_EN
      exp_d = ((k % 5) != 4);
`else
      exp_d = 1'b1;
`endif
      chk($sformatf("D.d_grant[%0d]", k), d_grant_s[0], exp_d);
      chk($sformatf("D.i_grant[%0d]", k), i_grant_s[0], !exp_d);
      tick();
    end
    clr_inputs();
    tick();

    // Mixed directed vectors on all instances, checked by the model
    for (int k = 0; k < 16; k++) begin
      for (int unsigned g = 0; g < NI; g++) begin
        i_req_s[g]    = vec_tab[k][3];
        d_req_s[g]    = vec_tab[k][2];
        redirect_s[g] = vec_tab[k][1];
        d_we_s[g]     = vec_tab[k][0] ? 4'b0011 : 4'b0000;
        i_addr_s[g]   = 32'h1000 + 32'(k * 16) + 32'(g * 4);
        d_addr_s[g]   = 32'h8000 + 32'(k * 8);
        d_wdata_s[g]  = 32'h0101_0101 * 32'(k + 1);
      end
      tick();
    end
    clr_inputs();
    repeat (6) tick();

    // E: reset mid-transaction at latency 4
    d_req_s[2] = 1'b1; d_addr_s[2] = 32'h3000;
    sample();
    chk("E.d_grant", d_grant_s[2], 1'b1);
    tick();
    d_req_s[2] = 1'b0;
    tick();
    reset = 1'b0; d_req_s[2] = 1'b1;
    sample();
    chk("E.rst_grant",  d_grant_s[2], 1'b0);
    chk("E.rst_en",     mem_en_s[2], 1'b0);
    chk("E.rst_addr",   mem_addr_s[2], 32'h0);
    chk("E.rst_rvalid", d_rvalid_s[2], 1'b0);
    tick();
    d_req_s[2] = 1'b0;
    tick();
    reset = 1'b1;
    for (int k = 0; k < 6; k++) begin
      sample();
      chk($sformatf("E.no_rvalid[%0d]", k), d_rvalid_s[2], 1'b0);
      chk($sformatf("E.no_en[%0d]", k), mem_en_s[2], 1'b0);
      tick();
    end

    repeat (2) tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
